// File: rtl/flash_phase_ctrl.sv
// flash_phase_ctrl: phase sequencer for a 16-LED bound-flasher bar.
// Owns the bar fill level and the phase FSM, and issues one-cycle step commands to the LED
// datapath (step_up lights bit level-1, step_dn clears bit level).
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   flick    in   start request in IDLE; kickback request at kick points in P2/P4
//   hold     in   freezes ticks, steps and phase changes while high
//   step_up  out  one-cycle pulse, datapath lights one LED
//   step_dn  out  one-cycle pulse, datapath clears one LED
//   level    out  lit-LED count after the current step, 0..MAX_LED
//   phase    out  0=IDLE, 1..6=P0..P5
//   busy     out  phase != IDLE
//   done     out  one-cycle pulse on completion of P5
// All outputs are registered.
module flash_phase_ctrl #(
  parameter int unsigned MAX_LED  = 16,
  parameter int unsigned LVL_A    = 6,
  parameter int unsigned LVL_B    = 11,
  parameter int unsigned LVL_C    = 5,
  parameter int unsigned STEP_DIV = 1,
  parameter int unsigned LW       = $clog2(MAX_LED + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flick,
  input  logic          hold,
  output logic          step_up,
  output logic          step_dn,
  output logic [LW-1:0] level,
  output logic [2:0]    phase,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StP0   = 3'd1,
    StP1   = 3'd2,
    StP2   = 3'd3,
    StP3   = 3'd4,
    StP4   = 3'd5,
    StP5   = 3'd6
  } phase_e;

  localparam int unsigned CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [CW-1:0] CntLast = CW'(STEP_DIV - 1);
  localparam logic [LW-1:0] LvlA    = LW'(LVL_A);
  localparam logic [LW-1:0] LvlB    = LW'(LVL_B);
  localparam logic [LW-1:0] LvlC    = LW'(LVL_C);
  localparam logic [LW-1:0] LvlMax  = LW'(MAX_LED);

  phase_e        phase_q, phase_d;
  logic [LW-1:0] level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          step_up_q, step_up_d;
  logic          step_dn_q, step_dn_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;

  logic [LW-1:0] target;
  logic          up_phase;
  logic          tick;
  logic          kick;

  always_comb begin
    target   = '0;
    up_phase = 1'b0;
    unique case (phase_q)
      StP0:    begin target = LvlA;   up_phase = 1'b1; end
      StP1:    target = '0;
      StP2:    begin target = LvlB;   up_phase = 1'b1; end
      StP3:    target = LvlC;
      StP4:    begin target = LvlMax; up_phase = 1'b1; end
      StP5:    target = '0;
      default: target = '0;
    endcase
  end

  assign tick = (phase_q != StIdle) && !hold && (cnt_q == CntLast);
  assign kick = ((phase_q == StP2) || (phase_q == StP4)) &&
                ((level_q == LvlA) || (level_q == LvlB)) && flick;

  always_comb begin
    phase_d   = phase_q;
    level_d   = level_q;
    cnt_d     = cnt_q;
    step_up_d = 1'b0;
    step_dn_d = 1'b0;
    done_d    = 1'b0;

    if (phase_q == StIdle) begin
      cnt_d = '0;
      if (flick && !hold) begin
        phase_d = StP0;
      end
    end else if (!hold) begin
      if (tick) begin
        cnt_d = '0;
        // Kick beats advance: P2 sitting at LVL_B with flick still kicks back.
        if (kick) begin
          phase_d = (phase_q == StP2) ? StP1 : StP3;
        end else if (level_q == target) begin
          if (phase_q == StP5) begin
            phase_d = StIdle;
            done_d  = 1'b1;
          end else begin
            phase_d = phase_e'(phase_q + 3'd1);
          end
        end else if (up_phase) begin
          if (level_q != LvlMax) begin
            step_up_d = 1'b1;
            level_d   = level_q + 1'b1;
          end
        end else begin
          if (level_q != '0) begin
            step_dn_d = 1'b1;
            level_d   = level_q - 1'b1;
          end
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign busy_d = (phase_d != StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= StIdle;
      level_q   <= '0;
      cnt_q     <= '0;
      step_up_q <= 1'b0;
      step_dn_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      step_up_q <= step_up_d;
      step_dn_q <= step_dn_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign step_up = step_up_q;
  assign step_dn = step_dn_q;
  assign level   = level_q;
  assign phase   = phase_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_flash_phase_ctrl.sv
// Self-checking bench for flash_phase_ctrl. Two instances: STEP_DIV=1 (d1) and STEP_DIV=4 (d4).
// Step pulses are checked against a per-instance scoreboard of expected (direction, level).
module tb_flash_phase_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       f1, h1, su1, sd1, busy1, done1;
  logic [4:0] lvl1;
  logic [2:0] ph1;
  logic       f4, h4, su4, sd4, busy4, done4;
  logic [4:0] lvl4;
  logic [2:0] ph4;

  int checks = 0;
  int errors = 0;

  // Entry encoding: 100 + level for step_up, level for step_dn.
  int exp1_q[$];
  int exp4_q[$];

  flash_phase_ctrl #(.STEP_DIV(1)) d1 (
    .clk(clk), .rst_n(rst_n), .flick(f1), .hold(h1), .step_up(su1), .step_dn(sd1),
    .level(lvl1), .phase(ph1), .busy(busy1), .done(done1)
  );

  flash_phase_ctrl #(.STEP_DIV(4)) d4 (
    .clk(clk), .rst_n(rst_n), .flick(f4), .hold(h4), .step_up(su4), .step_dn(sd4),
    .level(lvl4), .phase(ph4), .busy(busy4), .done(done4)
  );

  // Scoreboard monitors
  always @(negedge clk) begin
    int e, got;
    if (rst_n && (su1 || sd1)) begin
      checks++;
      got = (su1 ? 100 : 0) + int'(lvl1);
      if (su1 && sd1) begin
        errors++;
        $display("FAIL d1_step_both: step_up=%0b step_dn=%0b, required one-hot", su1, sd1);
      end else if (exp1_q.size() == 0) begin
        errors++;
        $display("FAIL d1_step_extra: got step code %0d, required no step", got);
      end else begin
        e = exp1_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL d1_step: got step code %0d, required %0d", got, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    int e, got;
    if (rst_n && (su4 || sd4)) begin
      checks++;
      got = (su4 ? 100 : 0) + int'(lvl4);
      if (su4 && sd4) begin
        errors++;
        $display("FAIL d4_step_both: step_up=%0b step_dn=%0b, required one-hot", su4, sd4);
      end else if (exp4_q.size() == 0) begin
        errors++;
        $display("FAIL d4_step_extra: got step code %0d, required no step", got);
      end else begin
        e = exp4_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL d4_step: got step code %0d, required %0d", got, e);
        end
      end
    end
  end

  task automatic push_up(input int sel, input int from, input int to);
    for (int v = from; v <= to; v++) begin
      if (sel == 1) exp1_q.push_back(100 + v);
      else exp4_q.push_back(100 + v);
    end
  endtask

  task automatic push_dn(input int sel, input int from, input int to);
    for (int v = from; v >= to; v--) begin
      if (sel == 1) exp1_q.push_back(v);
      else exp4_q.push_back(v);
    end
  endtask

  task automatic push_plain(input int sel);
    push_up(sel, 1, 6);
    push_dn(sel, 5, 0);
    push_up(sel, 1, 11);
    push_dn(sel, 10, 5);
    push_up(sel, 6, 16);
    push_dn(sel, 15, 0);
  endtask

  // Flick pulse in IDLE; returns at the negedge right after the P0 entry edge.
  task automatic start1();
    @(negedge clk);
    f1 = 1'b1;
    @(negedge clk);
    f1 = 1'b0;
    checks++;
    if (ph1 !== 3'd1 || busy1 !== 1'b1 || lvl1 !== 5'd0) begin
      errors++;
      $display("FAIL d1_start: phase=%0d busy=%0b level=%0d, required 1 1 0", ph1, busy1, lvl1);
    end
  endtask

  // mode 0: no flick; 1: kickback in P2 at 6 and P4 at 11; 2: flick off kick points only.
  task automatic run1(input int mode, output int n);
    bit seen_p2 = 0, kicked_p2 = 0, seen_p4 = 0, kicked_p4 = 0;
    n = 0;
    while (n < 400) begin
      if (mode == 1) begin
        if (ph1 == 3'd3) seen_p2 = 1;
        if (seen_p2 && !kicked_p2 && ph1 == 3'd2) begin
          kicked_p2 = 1;
          checks++;
          if (lvl1 !== 5'd6) begin
            errors++;
            $display("FAIL kick_a_level: level=%0d after kick, required 6", lvl1);
          end
        end
        if (kicked_p2 && ph1 == 3'd5) seen_p4 = 1;
        if (seen_p4 && !kicked_p4 && ph1 == 3'd4) begin
          kicked_p4 = 1;
          checks++;
          if (lvl1 !== 5'd11) begin
            errors++;
            $display("FAIL kick_b_level: level=%0d after kick, required 11", lvl1);
          end
        end
        f1 = (ph1 == 3'd3 && !kicked_p2) || (ph1 == 3'd5 && lvl1 == 5'd11 && !kicked_p4);
      end else if (mode == 2) begin
        f1 = (ph1 == 3'd1) || (ph1 == 3'd2) || (ph1 == 3'd4) || (ph1 == 3'd6) ||
             (ph1 == 3'd5 && lvl1 == 5'd8);
      end else begin
        f1 = 1'b0;
      end
      @(negedge clk);
      n++;
      if (done1) break;
    end
    f1 = 1'b0;
    if (mode == 1) begin
      checks++;
      if (!(kicked_p2 && kicked_p4)) begin
        errors++;
        $display("FAIL kick_seen: kick_a=%0b kick_b=%0b, required 1 1", kicked_p2, kicked_p4);
      end
    end
  endtask

  task automatic check_end1(input string name, input int n, input int want);
    checks++;
    if (n !== want) begin
      errors++;
      $display("FAIL %s_done_cycle: done after %0d cycles, required %0d", name, n, want);
    end
    checks++;
    if (exp1_q.size() != 0) begin
      errors++;
      $display("FAIL %s_steps_left: %0d steps missing, required 0", name, exp1_q.size());
    end
    exp1_q.delete();
    @(negedge clk);
    checks++;
    if (done1 !== 1'b0 || ph1 !== 3'd0 || busy1 !== 1'b0 || lvl1 !== 5'd0) begin
      errors++;
      $display("FAIL %s_after_done: done=%0b phase=%0d busy=%0b level=%0d, required 0 0 0 0",
               name, done1, ph1, busy1, lvl1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    f1 = 0; h1 = 0; f4 = 0; h4 = 0;
    #17;
    checks++;
    if (ph1 !== 3'd0 || lvl1 !== 5'd0 || busy1 !== 1'b0 || su1 !== 1'b0 || sd1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_d1: phase=%0d level=%0d busy=%0b, required 0 0 0", ph1, lvl1, busy1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (ph1 !== 0 || lvl1 !== 0 || su1 | sd1 | done1 | busy1 ||
          ph4 !== 0 || lvl4 !== 0 || su4 | sd4 | done4 | busy4) begin
        errors++;
        $display("FAIL idle: d1 phase=%0d level=%0d d4 phase=%0d level=%0d, required all 0",
                 ph1, lvl1, ph4, lvl4);
      end
    end
  endtask

  task automatic test_full_run();
    int n;
    push_plain(1);
    start1();
    run1(0, n);
    check_end1("full", n, 62);
  endtask

  task automatic test_kickback();
    int n;
    push_up(1, 1, 6);
    push_dn(1, 5, 0);
    push_up(1, 1, 6);
    push_dn(1, 5, 0);
    push_up(1, 1, 11);
    push_dn(1, 10, 5);
    push_up(1, 6, 11);
    push_dn(1, 10, 5);
    push_up(1, 6, 16);
    push_dn(1, 15, 0);
    start1();
    run1(1, n);
    check_end1("kick", n, 90);
  endtask

  task automatic test_flick_ignored();
    int n;
    push_plain(1);
    start1();
    run1(2, n);
    check_end1("ignored", n, 62);
  endtask

  task automatic test_prescaler_hold();
    int n = 0;
    int npulse = 0;
    bit held = 0;
    push_plain(4);
    @(negedge clk);
    f4 = 1'b1;
    @(negedge clk);
    f4 = 1'b0;
    while (n < 600) begin
      if (!held && ph4 == 3'd3 && lvl4 == 5'd5) begin
        held = 1;
        h4 = 1'b1;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          n++;
          checks++;
          if (lvl4 !== 5'd5 || ph4 !== 3'd3 || su4 || sd4) begin
            errors++;
            $display("FAIL hold_frozen: level=%0d phase=%0d up=%0b dn=%0b, required 5 3 0 0",
                     lvl4, ph4, su4, sd4);
          end
        end
        h4 = 1'b0;
      end
      @(negedge clk);
      n++;
      if ((su4 || sd4) && npulse < 2) begin
        npulse++;
        checks++;
        if (n !== 4 * npulse) begin
          errors++;
          $display("FAIL div4_pulse%0d: at cycle %0d, required %0d", npulse, n, 4 * npulse);
        end
      end
      if (done4) break;
    end
    checks++;
    if (n !== 258) begin
      errors++;
      $display("FAIL div4_done_cycle: done after %0d cycles, required 258", n);
    end
    checks++;
    if (exp4_q.size() != 0) begin
      errors++;
      $display("FAIL div4_steps_left: %0d steps missing, required 0", exp4_q.size());
    end
    exp4_q.delete();
  endtask

  task automatic test_reset_mid_run();
    int n = 0;
    push_plain(1);
    start1();
    while (n < 200 && !(ph1 == 3'd5 && lvl1 == 5'd9)) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL midrun_reach: P4 level 9 not reached in %0d cycles, required reached", n);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (lvl1 !== 5'd0 || ph1 !== 3'd0 || busy1 !== 1'b0 || su1 !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: level=%0d phase=%0d busy=%0b, required 0 0 0",
               lvl1, ph1, busy1);
    end
    exp1_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (ph1 !== 3'd0 || lvl1 !== 5'd0 || su1 | sd1) begin
        errors++;
        $display("FAIL post_reset_idle: phase=%0d level=%0d, required 0 0", ph1, lvl1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_kickback();
    test_flick_ignored();
    test_prescaler_hold();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
